// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller
//
// Accepts one execute-stage result at a time. The result is either a plain
// register write, a store or a load. Memory operations go out as a single bus
// request (req/gnt handshake). Loads then wait for rvalid. Every operation
// ends with a one-cycle writeback strobe.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/out_ready  result handshake (ready only while idle)
//   in_rd_id/in_rd_we   destination register and its write enable
//   in_data             ALU result or store data
//   in_mem_addr         byte address
//   in_mem_we           unshifted store mask (0001 SB, 0011 SH, 1111 SW)
//   in_mem_re           one-hot load type (LB, LH, LW, LBU, LHU)
//   out_bus_*           word-aligned bus request with lane enables/data
//   in_bus_gnt          request accepted
//   in_bus_rvalid/rdata read data return
//   out_wb_*            writeback strobe, register, enable, value
//   out_err             misaligned-access flag (LSU_MISALIGN_TRAP_EN only)
//
// Configuration
//   LSU_MISALIGN_TRAP_EN defined   : a misaligned half/word access skips the
//                                    bus, writes nothing back and raises
//                                    out_err together with out_wb_valid.
//   LSU_MISALIGN_TRAP_EN undefined : a misaligned half/word access is performed
//                                    at lane offset 0 (aligned).
// -----------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        out_ready,
  input  logic [4:0]  in_rd_id,
  input  logic        in_rd_we,
  input  logic [31:0] in_data,
  input  logic [31:0] in_mem_addr,
  input  logic [3:0]  in_mem_we,
  input  logic [4:0]  in_mem_re,
  output logic        out_bus_req,
  output logic [31:0] out_bus_addr,
  output logic        out_bus_we,
  output logic [3:0]  out_bus_be,
  output logic [31:0] out_bus_wdata,
  input  logic        in_bus_gnt,
  input  logic        in_bus_rvalid,
  input  logic [31:0] in_bus_rdata,
  output logic        out_wb_valid,
  output logic [4:0]  out_wb_rd_id,
  output logic        out_wb_we,
  output logic [31:0] out_wb_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        out_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  // Captured operation
  logic [4:0]  rd_id;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        is_store;
  logic [4:0]  ld_type;
  logic [1:0]  off;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        err;
`endif

  // Input-side decode
  logic        in_store;
  logic        in_load;
  logic        in_half;
  logic        in_word;
  logic        in_misalign;
  logic        in_trap;
  logic        mem_go;
  logic [1:0]  in_off;
  logic [3:0]  in_size_mask;
  logic [3:0]  in_be;
  logic [4:0]  in_ld_type;

  // Shift the returned word down to the addressed lane, then size/extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  sh,
                                               input logic [4:0]  typ);
    logic [31:0] w;
    logic [31:0] r;
    w = rdata >> {sh, 3'b000};
    if (typ[0]) begin
      r = {{24{w[7]}}, w[7:0]};
    end else if (typ[1]) begin
      r = {{16{w[15]}}, w[15:0]};
    end else if (typ[3]) begin
      r = {24'h000000, w[7:0]};
    end else if (typ[4]) begin
      r = {16'h0000, w[15:0]};
    end else if (typ[2]) begin
      r = w;
    end else begin
      r = w;
    end
    return r;
  endfunction

  // Classify the incoming operation and precompute its bus lane image.
  // A store wins over a load when both masks are set.
  always_comb begin
    in_store   = |in_mem_we;
    in_load    = ~in_store & (|in_mem_re);
    in_half    = 1'b0;
    in_word    = 1'b0;
    in_ld_type = 5'b00000;
    if (in_store) begin
      in_half = (in_mem_we == 4'b0011);
      in_word = (in_mem_we == 4'b1111);
    end else if (in_load) begin
      in_ld_type = in_mem_re;
      in_word    = in_mem_re[2];
      in_half    = ~in_mem_re[2] & (in_mem_re[1] | in_mem_re[4]);
    end else begin
      in_ld_type = 5'b00000;
    end
    in_misalign = (in_half & in_mem_addr[0]) |
                  (in_word & (in_mem_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    in_trap = in_misalign;
    in_off  = in_mem_addr[1:0];
`else
    // Misaligned half/word accesses are performed at lane 0.
    in_trap = 1'b0;
    if (in_misalign) begin
      in_off = 2'b00;
    end else begin
      in_off = in_mem_addr[1:0];
    end
`endif
    mem_go = (in_store | in_load) & ~in_trap;
    if (in_word) begin
      in_size_mask = 4'b1111;
    end else if (in_half) begin
      in_size_mask = 4'b0011;
    end else begin
      in_size_mask = 4'b0001;
    end
    if (in_store) begin
      in_be = in_mem_we << in_off;
    end else begin
      in_be = in_size_mask << in_off;
    end
  end

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; gnt/rvalid waits are unbounded by design.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (mem_go) begin
            next_state = REQ;
          end else begin
            next_state = DONE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        if (in_bus_gnt) begin
          if (is_store) begin
            next_state = DONE;
          end else begin
            next_state = WAIT;
          end
        end else begin
          next_state = REQ;
        end
      end
      WAIT: begin
        // Only looked at from the cycle after gnt, so rvalid coincident
        // with gnt is never taken.
        if (in_bus_rvalid) begin
          next_state = DONE;
        end else begin
          next_state = WAIT;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operation capture, load-data capture and error flag housekeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_id     <= 5'd0;
      wb_we     <= 1'b0;
      wb_data   <= 32'h0000_0000;
      is_store  <= 1'b0;
      ld_type   <= 5'b00000;
      off       <= 2'b00;
      bus_addr  <= 32'h0000_0000;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
`ifdef LSU_MISALIGN_TRAP_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rd_id     <= in_rd_id;
            is_store  <= in_store;
            ld_type   <= in_ld_type;
            off       <= in_off;
            bus_addr  <= {in_mem_addr[31:2], 2'b00};
            bus_we    <= in_store;
            bus_be    <= in_be;
            bus_wdata <= in_data << {in_off, 3'b000};
            wb_we     <= in_rd_we & (in_rd_id != 5'd0) & ~in_store & ~in_trap;
            wb_data   <= (in_store | in_load) ? 32'h0000_0000 : in_data;
`ifdef LSU_MISALIGN_TRAP_EN
            err       <= in_trap;
`endif
          end
        end
        WAIT: begin
          if (in_bus_rvalid) begin
            wb_data <= load_extract(in_bus_rdata, off, ld_type);
          end
        end
`ifdef LSU_MISALIGN_TRAP_EN
        DONE: begin
          err <= 1'b0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Outputs decode only from registers, so they follow reset asynchronously.
  assign out_ready     = (state == IDLE);
  assign out_bus_req   = (state == REQ);
  assign out_bus_addr  = bus_addr;
  assign out_bus_we    = bus_we;
  assign out_bus_be    = bus_be;
  assign out_bus_wdata = bus_wdata;
  assign out_wb_valid  = (state == DONE);
  assign out_wb_rd_id  = rd_id;
  assign out_wb_we     = wb_we;
  assign out_wb_data   = wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  assign out_err       = err;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// Directed scenarios followed by randomized operations; expected values come
// from a byte-lane arithmetic reference model kept here.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  in_rd_id;
  logic        in_rd_we;
  logic [31:0] in_data;
  logic [31:0] in_mem_addr;
  logic [3:0]  in_mem_we;
  logic [4:0]  in_mem_re;
  logic        out_bus_req;
  logic [31:0] out_bus_addr;
  logic        out_bus_we;
  logic [3:0]  out_bus_be;
  logic [31:0] out_bus_wdata;
  logic        in_bus_gnt;
  logic        in_bus_rvalid;
  logic [31:0] in_bus_rdata;
  logic        out_wb_valid;
  logic [4:0]  out_wb_rd_id;
  logic        out_wb_we;
  logic [31:0] out_wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        out_err;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_rd_id      (in_rd_id),
    .in_rd_we      (in_rd_we),
    .in_data       (in_data),
    .in_mem_addr   (in_mem_addr),
    .in_mem_we     (in_mem_we),
    .in_mem_re     (in_mem_re),
    .out_bus_req   (out_bus_req),
    .out_bus_addr  (out_bus_addr),
    .out_bus_we    (out_bus_we),
    .out_bus_be    (out_bus_be),
    .out_bus_wdata (out_bus_wdata),
    .in_bus_gnt    (in_bus_gnt),
    .in_bus_rvalid (in_bus_rvalid),
    .in_bus_rdata  (in_bus_rdata),
    .out_wb_valid  (out_wb_valid),
    .out_wb_rd_id  (out_wb_rd_id),
    .out_wb_we     (out_wb_we),
    .out_wb_data   (out_wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .out_err       (out_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete operation: issue, bus handshake (if any), writeback check.
  task automatic run_op(input logic [4:0] rd, input logic rwe, input logic [31:0] data,
                        input logic [31:0] addr, input logic [3:0] mwe, input logic [4:0] mre,
                        input int gdly, input int rdly, input logic [31:0] rdata,
                        input bit junk_rv);
    int          size;
    int          offs;
    bit          store;
    bit          load;
    bit          sgn;
    bit          trap;
    bit          mem;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] mask;
    logic [31:0] val;
    logic        exp_we;

    // Reference model: sizes in bytes, lane offset in bytes.
    store = (mwe != 4'd0);
    load  = !store && (mre != 5'd0);
    size  = 1;
    sgn   = 1'b0;
    if (store) size = (mwe == 4'b1111) ? 4 : ((mwe == 4'b0011) ? 2 : 1);
    else if (load) begin
      if (mre[2]) size = 4;
      else if (mre[1] || mre[4]) size = 2;
      sgn = mre[0] || mre[1];
    end
    offs = int'(addr % 32'd4);
    trap = 1'b0;
    if ((store || load) && (offs % size != 0)) begin
`ifdef LSU_MISALIGN_TRAP_EN
      trap = 1'b1;
`else
      offs = 0;
`endif
    end
    mem       = (store || load) && !trap;
    exp_be    = 4'(((32'd1 << size) - 32'd1) << offs);
    exp_wdata = data << (8 * offs);
    mask      = (32'd1 << (8 * size)) - 32'd1;
    val       = (rdata >> (8 * offs)) & mask;
    if (sgn && val[8 * size - 1]) val = val | ~mask;
    exp_we    = rwe && (rd != 5'd0) && !store && !trap;

    check("ready_idle", out_ready, 1);
    in_rd_id = rd; in_rd_we = rwe; in_data = data; in_mem_addr = addr;
    in_mem_we = mwe; in_mem_re = mre; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = $urandom; in_mem_addr = $urandom; in_rd_id = 5'($urandom);
    in_mem_we = 4'($urandom); in_mem_re = 5'($urandom); in_rd_we = 1'($urandom);
    if (mem) begin
      for (int i = 0; i <= gdly; i++) begin
        check("bus_req",   out_bus_req, 1);
        check("ready_busy", out_ready, 0);
        check("bus_addr",  out_bus_addr, {addr[31:2], 2'b00});
        check("bus_we",    out_bus_we, store);
        check("bus_be",    out_bus_be, exp_be);
        if (store) check("bus_wdata", out_bus_wdata, exp_wdata);
        if (i == gdly) begin
          in_bus_gnt = 1'b1;
          if (junk_rv && load) begin
            in_bus_rvalid = 1'b1;
            in_bus_rdata  = ~rdata;
          end
        end
        @(negedge clk);
      end
      in_bus_gnt = 1'b0;
      in_bus_rvalid = 1'b0;
      if (load) begin
        for (int i = 0; i <= rdly; i++) begin
          check("wait_req",   out_bus_req, 0);
          check("wait_wbval", out_wb_valid, 0);
          if (i == rdly) begin
            in_bus_rvalid = 1'b1;
            in_bus_rdata  = rdata;
          end
          @(negedge clk);
        end
        in_bus_rvalid = 1'b0;
        in_bus_rdata  = $urandom;
      end
    end
    check("wb_valid", out_wb_valid, 1);
    check("wb_req0",  out_bus_req, 0);
    check("wb_rd_id", out_wb_rd_id, rd);
    check("wb_we",    out_wb_we, exp_we);
    if (load && !trap) check("wb_data_ld", out_wb_data, val);
    else if (!store && !load) check("wb_data_alu", out_wb_data, data);
`ifdef LSU_MISALIGN_TRAP_EN
    check("err", out_err, trap);
`endif
    @(negedge clk);
    check("wb_pulse", out_wb_valid, 0);
    check("ready_back", out_ready, 1);
  endtask

  initial begin
    logic [3:0] mwe;
    logic [4:0] mre;
    int         kind;
    int         sel;

    rst_n = 1'b0; in_valid = 1'b0; in_rd_id = 5'd0; in_rd_we = 1'b0;
    in_data = 32'd0; in_mem_addr = 32'd0; in_mem_we = 4'd0; in_mem_re = 5'd0;
    in_bus_gnt = 1'b0; in_bus_rvalid = 1'b0; in_bus_rdata = 32'd0;
    #1;
    check("rst_ready",  out_ready, 1);
    check("rst_req",    out_bus_req, 0);
    check("rst_wbval",  out_wb_valid, 0);
    check("rst_addr",   out_bus_addr, 32'd0);
    check("rst_wbdata", out_wb_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    run_op(5'd5, 1'b1, 32'h12345678, 32'h0000_0000, 4'b0000, 5'b00000, 0, 0, 32'd0, 1'b0);
    run_op(5'd3, 1'b1, 32'h0000_00AB, 32'h0000_1003, 4'b0001, 5'b00000, 0, 0, 32'd0, 1'b0);
    run_op(5'd7, 1'b1, 32'd0, 32'h0000_2001, 4'b0000, 5'b00001, 3, 0, 32'h0000_80FF, 1'b0);
    run_op(5'd7, 1'b1, 32'd0, 32'h0000_2001, 4'b0000, 5'b01000, 3, 0, 32'h0000_80FF, 1'b0);
    run_op(5'd8, 1'b1, 32'd0, 32'h0000_2002, 4'b0000, 5'b00010, 0, 1, 32'hBEEF_0000, 1'b1);
    run_op(5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 5'b00000, 0, 0, 32'd0, 1'b0);
    run_op(5'd4, 1'b1, 32'h1122_3344, 32'h0000_4002, 4'b0011, 5'b00100, 1, 0, 32'd0, 1'b0);
    run_op(5'd9, 1'b1, 32'd0, 32'h0000_3002, 4'b0000, 5'b00100, 0, 0, 32'hCAFE_BABE, 1'b0);
    run_op(5'd10, 1'b1, 32'd0, 32'h0000_5003, 4'b0000, 5'b10000, 2, 2, 32'h8765_4321, 1'b0);

    // Reset while waiting for read data: access abandoned, stale rvalid ignored
    in_rd_id = 5'd6; in_rd_we = 1'b1; in_mem_addr = 32'h0000_6000;
    in_mem_we = 4'b0000; in_mem_re = 5'b00100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_bus_gnt = 1'b1;
    @(negedge clk);
    in_bus_gnt = 1'b0;
    check("wait_req", out_bus_req, 0);
    rst_n = 1'b0;
    #1;
    check("rstw_req",   out_bus_req, 0);
    check("rstw_ready", out_ready, 1);
    check("rstw_addr",  out_bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_bus_rvalid = 1'b1; in_bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    in_bus_rvalid = 1'b0;
    check("stale_wbval", out_wb_valid, 0);
    check("stale_ready", out_ready, 1);
    @(negedge clk);
    check("stale_wbval2", out_wb_valid, 0);

    // Reset during REQ drops the request before any clock edge
    in_mem_we = 4'b1111; in_mem_re = 5'b00000; in_data = 32'hA5A5_A5A5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("req_up", out_bus_req, 1);
    rst_n = 1'b0;
    #1;
    check("rstr_req", out_bus_req, 0);
    check("rstr_be",  out_bus_be, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      mwe  = 4'b0000;
      mre  = 5'b00000;
      case (kind)
        1: begin
          sel = $urandom_range(0, 2);
          mwe = (sel == 0) ? 4'b0001 : ((sel == 1) ? 4'b0011 : 4'b1111);
          if ($urandom_range(0, 3) == 0) mre = 5'(5'b00001 << $urandom_range(0, 4));
        end
        2: mre = 5'(5'b00001 << $urandom_range(0, 4));
        default: ;
      endcase
      run_op(5'($urandom), 1'($urandom), $urandom, $urandom, mwe, mre,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Both ports are listed first below.
REQ-002 The ports SHALL be:
- clk  in  1  : rising-edge clock
- rst_n  in  1  : asynchronous, active-low reset
- in_valid  in  1  : execute-stage result valid
- out_ready  out  1  : block can accept a result
- in_rd_id  in  5  : destination register
- in_rd_we  in  1  : register write enable
- in_data  in  32  : ALU result, or store data
- in_mem_addr  in  32  : byte address
- in_mem_we  in  4  : store mask, unshifted; 0001 = SB, 0011 = SH, 1111 = SW
- in_mem_re  in  5  : one-hot load type; bit0 LB, bit1 LH, bit2 LW, bit3 LBU, bit4 LHU
- out_bus_req  out  1  : bus request
- out_bus_addr  out  32  : word-aligned address, in_mem_addr with bits[1:0] = 0
- out_bus_we  out  1  : 1 = write
- out_bus_be  out  4  : byte enables
- out_bus_wdata  out  32  : lane-aligned write data
- in_bus_gnt  in  1  : request accepted
- in_bus_rvalid  in  1  : read data valid
- in_bus_rdata  in  32  : read data
- out_wb_valid  out  1  : one-cycle writeback strobe
- out_wb_rd_id  out  5  : writeback register
- out_wb_we  out  1  : writeback enable
- out_wb_data  out  32  : writeback value
- out_err  out  1  : misaligned access; present only with the macro in REQ-019

Function
REQ-003 The block SHALL use a state machine with states IDLE, REQ, WAIT and DONE. out_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE with in_valid=1, the block SHALL capture all inputs into registers.
- Store (in_mem_we≠0): go to REQ.
- Load (in_mem_re≠0): go to REQ.
- Otherwise: go to DONE.
REQ-005 If in_mem_we≠0 and in_mem_re≠0 together, the block SHALL treat the operation as a store and ignore in_mem_re.
REQ-006 In REQ, out_bus_req SHALL be 1 and the bus outputs SHALL hold constant until in_bus_gnt=1.
- On gnt, a store goes to DONE.
- On gnt, a load goes to WAIT.
REQ-007 In WAIT, the block SHALL capture in_bus_rdata when in_bus_rvalid=1 and go to DONE. rvalid arriving in the same cycle as gnt SHALL NOT be recognised.
REQ-008 In DONE, the block SHALL assert out_wb_valid for exactly one cycle and return to IDLE. out_wb_* SHALL be held stable during that cycle.
REQ-009 The store lane shift SHALL use off = addr[1:0]:
- out_bus_be = in_mem_we << off, truncated to 4 bits.
- out_bus_wdata = in_data << (8*off).
REQ-010 For loads, out_bus_be SHALL be the load-size mask shifted by off, and out_bus_we SHALL be 0.
REQ-011 The load extract SHALL be:
- rdata >> (8*off), then select byte or half.
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- LW passes the word unchanged.
REQ-012 Writeback data SHALL be selected as follows:
- Store: out_wb_we = 0.
- Load: out_wb_data = extracted value, out_wb_we = captured rd_we.
- Non-memory: out_wb_data = captured in_data, out_wb_we = captured rd_we.
REQ-013 If the captured rd_id = 0, out_wb_we SHALL be 0.
REQ-014 Latency from the acceptance cycle N SHALL be:
- Non-memory: wb_valid at N+1.
- Store with immediate gnt: wb_valid at N+2.
- Load with immediate gnt and rvalid one cycle later: wb_valid at N+3.
REQ-015 The block SHALL NOT bound the number of gnt or rvalid wait cycles. It SHALL have no timeout.
REQ-016 out_bus_req SHALL be 0 in every state other than REQ.

Reset
REQ-017 While rst_n=0, the state SHALL be IDLE and all outputs SHALL be 0 except out_ready. This SHALL take effect immediately, without waiting for a clock edge.
REQ-018 A reset asserted during REQ or WAIT SHALL abandon the access. out_bus_req SHALL drop asynchronously, and a later stale in_bus_rvalid in IDLE SHALL be ignored.

Configuration
REQ-019 The macro LSU_MISALIGN_TRAP_EN SHALL control misaligned-access handling. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
- Defined: the block SHALL skip REQ, go directly to DONE with out_wb_we=0, and assert out_err with out_wb_valid.
- Undefined: out_err SHALL NOT exist, off SHALL be forced to 0 for half and word accesses, and the access SHALL proceed aligned.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Non-memory: in_data=0x12345678, rd_id=5, rd_we=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_we=1.
- SB: addr=0x1003, in_data=0xAB, we=0001, gnt immediate -> bus_be=1000, bus_wdata=0xAB000000, bus_addr=0x1000, wb_we=0.
- LB: addr=0x2001, rdata=0x0000_80FF, gnt delayed 3 cycles -> wb_data=0xFFFFFF80. The same access as LBU -> wb_data=0x00000080.
- LH: addr=0x2002, rdata=0xBEEF0000 -> wb_data=0xFFFFBEEF, bus_be=1100.
- Reset: rst_n pulled low in WAIT -> out_bus_req=0 immediately. A later rvalid produces no wb_valid.
- LW with LSU_MISALIGN_TRAP_EN defined: addr=0x3002 -> no bus_req, out_err=1, wb_valid=1, wb_we=0.
